// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM read-port arbiter: response-owner state
// encoding, the error-response data value and the word-index helper.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP_IF = 2'd1,
    ST_RESP_D  = 2'd2
  } arb_state_e;

  localparam logic [63:0] ERR_RDATA = 64'd0;

  // Word index of a byte address, zero-extended so any WIDTH up to 64 fits.
  function automatic logic [63:0] word_idx(input logic [63:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Saturating counter of consecutive fetch denials; sat_o marks that the
// fetch port must win the next contested grant.
module rom_arb_starve_cnt #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == CW'(STARVE_MAX));
  assign cnt_o = cnt_q;

  // Clear has priority so a granted fetch always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction-ROM read port between fetch (IF) and
// data (D) reads: D has priority, a starvation guard keeps fetch moving.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned LENGTH     = 32,
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic [WIDTH-1:0] d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output arb_state_e       dbg_state_o,
  output logic [CW-1:0]    dbg_starve_cnt_o
);

  // Handshake: a requester raises req with a stable addr and holds both until
  // the combinational gnt; the registered rvalid follows exactly one cycle later.

  arb_state_e       state_q;
  logic [WIDTH-1:0] rom_addr_q;
  logic [WIDTH-1:0] if_rdata_q, d_rdata_q;
  logic             if_err_q, d_err_q;

  logic             starve_sat;
  logic             d_win, if_win, any_win;
  logic [WIDTH-1:0] sel_addr;
  logic             req_err;
  logic [WIDTH-1:0] resp_data;

  // Grants are suppressed while reset is asserted.
  assign d_win   = rst_n && d_req && !(if_req && starve_sat);
  assign if_win  = rst_n && if_req && !d_win;
  assign any_win = d_win || if_win;

  assign sel_addr  = d_win ? d_addr : if_addr;
  assign req_err   = (sel_addr[1:0] != 2'b00) ||
                     (word_idx(64'(sel_addr)) >= 64'(LENGTH));
  assign resp_data = req_err ? WIDTH'(ERR_RDATA) : rom_data;

  // Erroring requests never reach the ROM, so the address bus stays put.
  assign rom_addr = (any_win && !req_err) ? sel_addr : rom_addr_q;

  assign if_gnt    = if_win;
  assign d_gnt     = d_win;
  assign if_rvalid = (state_q == ST_RESP_IF);
  assign d_rvalid  = (state_q == ST_RESP_D);
  assign if_err    = if_rvalid && if_err_q;
  assign d_err     = d_rvalid && d_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign dbg_state_o = state_q;

  rom_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (if_req && !if_win),
    .clr_i  (if_win || !if_req),
    .cnt_o  (dbg_starve_cnt_o),
    .sat_o  (starve_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr;
      if (d_win) begin
        state_q   <= ST_RESP_D;
        d_rdata_q <= resp_data;
        d_err_q   <= req_err;
      end else if (if_win) begin
        state_q    <= ST_RESP_IF;
        if_rdata_q <= resp_data;
        if_err_q   <= req_err;
      end else begin
        state_q <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: per-cycle vector table plus a
// reset-in-flight sequence, against a small ROM model.
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned LENGTH     = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req, d_req;
  logic [WIDTH-1:0]  if_addr, d_addr;
  logic              if_gnt, if_rvalid, if_err;
  logic              d_gnt, d_rvalid, d_err;
  logic [WIDTH-1:0]  if_rdata, d_rdata, rom_addr, rom_data;
  arb_state_e        dbg_state;
  logic [2:0]        dbg_cnt;

  int checks;
  int errors;

  rom_port_arbiter #(
    .WIDTH      (WIDTH),
    .LENGTH     (LENGTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_gnt           (if_gnt),
    .if_rvalid        (if_rvalid),
    .if_rdata         (if_rdata),
    .if_err           (if_err),
    .d_req            (d_req),
    .d_addr           (d_addr),
    .d_gnt            (d_gnt),
    .d_rvalid         (d_rvalid),
    .d_rdata          (d_rdata),
    .d_err            (d_err),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .dbg_state_o      (dbg_state),
    .dbg_starve_cnt_o (dbg_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents
  function automatic logic [31:0] mem_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  always_comb begin
    rom_data = 32'hDEAD_BEEF;
    if (rom_addr[31:2] < 30'(LENGTH)) rom_data = mem_word(int'(rom_addr[31:2]));
  end

  // Requesters must hold req until granted.
  logic if_pend, d_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pend <= 1'b0;
      d_pend  <= 1'b0;
    end else begin
      assert (!if_pend || if_req) else $error("protocol violation: if_req dropped before if_gnt");
      assert (!d_pend || d_req) else $error("protocol violation: d_req dropped before d_gnt");
      if_pend <= if_req && !if_gnt;
      d_pend  <= d_req && !d_gnt;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic        exp_if_gnt;
    logic        exp_d_gnt;
    logic [31:0] exp_rom_addr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic eig, input logic edg,
                         input logic [31:0] era, input logic eer,
                         input logic [31:0] erd, input int ecnt);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_addr = da;
    v.exp_if_gnt = eig; v.exp_d_gnt = edg; v.exp_rom_addr = era;
    v.exp_err = eer; v.exp_rdata = erd; v.exp_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
  endtask

  logic [31:0] last_if, last_d;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);

    // Single IF, back-to-back IF, error cases, valid D
    add_vec(1, 32'h08, 0, 32'h0,  1, 0, 32'h08, 0, mem_word(2), 0);
    add_vec(1, 32'h00, 0, 32'h0,  1, 0, 32'h00, 0, mem_word(0), 0);
    add_vec(1, 32'h04, 0, 32'h0,  1, 0, 32'h04, 0, mem_word(1), 0);
    add_vec(1, 32'h08, 0, 32'h0,  1, 0, 32'h08, 0, mem_word(2), 0);
    add_vec(0, 32'h0,  1, 32'h06, 0, 1, 32'h08, 1, 32'h0,       0);
    add_vec(1, 32'h80, 0, 32'h0,  1, 0, 32'h08, 1, 32'h0,       0);
    add_vec(0, 32'h0,  1, 32'h10, 0, 1, 32'h10, 0, mem_word(4), 0);
    // Contention: D wins four times, IF forced on the fifth, then D again
    for (int i = 1; i <= 4; i++)
      add_vec(1, 32'h14, 1, 32'h18, 0, 1, 32'h18, 0, mem_word(6), i);
    add_vec(1, 32'h14, 1, 32'h18, 1, 0, 32'h14, 0, mem_word(5), 0);
    add_vec(1, 32'h14, 1, 32'h18, 0, 1, 32'h18, 0, mem_word(6), 1);
    add_vec(1, 32'h14, 0, 32'h0,  1, 0, 32'h14, 0, mem_word(5), 0);
    // Last valid word
    add_vec(1, 32'h7C, 0, 32'h0,  1, 0, 32'h7C, 0, mem_word(31), 0);
    // Idle: address bus holds
    for (int i = 0; i < 10; i++)
      add_vec(0, 32'h0, 0, 32'h0, 0, 0, 32'h7C, 0, 32'h0, 0);

    #1;
    check("reset if_gnt",   32'(if_gnt),    32'h0);
    check("reset d_gnt",    32'(d_gnt),     32'h0);
    check("reset if_rvalid", 32'(if_rvalid), 32'h0);
    check("reset d_rvalid", 32'(d_rvalid),  32'h0);
    check("reset if_rdata", if_rdata,       32'h0);
    check("reset d_rdata",  d_rdata,        32'h0);
    check("reset rom_addr", rom_addr,       32'h0);
    check("reset state",    32'(dbg_state), 32'(ST_IDLE));
    check("reset cnt",      32'(dbg_cnt),   32'h0);
    last_if = 32'h0;
    last_d  = 32'h0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      vec_t v;
      logic [31:0] exp_state;
      v = vecs[k];
      @(negedge clk);
      drive(v.if_req, v.if_addr, v.d_req, v.d_addr);
      #2;
      check($sformatf("v%0d if_gnt", k),   32'(if_gnt), 32'(v.exp_if_gnt));
      check($sformatf("v%0d d_gnt", k),    32'(d_gnt),  32'(v.exp_d_gnt));
      check($sformatf("v%0d rom_addr", k), rom_addr,    v.exp_rom_addr);
      @(posedge clk);
      #1;
      if (v.exp_if_gnt) last_if = v.exp_rdata;
      if (v.exp_d_gnt)  last_d  = v.exp_rdata;
      exp_state = v.exp_d_gnt ? 32'(ST_RESP_D) : (v.exp_if_gnt ? 32'(ST_RESP_IF) : 32'(ST_IDLE));
      check($sformatf("v%0d if_rvalid", k), 32'(if_rvalid), 32'(v.exp_if_gnt));
      check($sformatf("v%0d d_rvalid", k),  32'(d_rvalid),  32'(v.exp_d_gnt));
      check($sformatf("v%0d if_err", k),    32'(if_err),    32'(v.exp_if_gnt && v.exp_err));
      check($sformatf("v%0d d_err", k),     32'(d_err),     32'(v.exp_d_gnt && v.exp_err));
      check($sformatf("v%0d if_rdata", k),  if_rdata,       last_if);
      check($sformatf("v%0d d_rdata", k),   d_rdata,        last_d);
      check($sformatf("v%0d starve_cnt", k), 32'(dbg_cnt),  32'(v.exp_cnt));
      check($sformatf("v%0d state", k),     32'(dbg_state), exp_state);
    end

    // Reset between a grant and its clock edge
    @(negedge clk);
    drive(1'b1, 32'h0C, 1'b1, 32'h00);
    @(posedge clk);
    #1;
    check("rst_seq cnt before", 32'(dbg_cnt), 32'h1);
    @(negedge clk);
    #2;
    check("rst_seq d_gnt before", 32'(d_gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_seq d_gnt in reset",  32'(d_gnt),  32'h0);
    check("rst_seq if_gnt in reset", 32'(if_gnt), 32'h0);
    check("rst_seq cnt in reset",    32'(dbg_cnt), 32'h0);
    check("rst_seq rom_addr",        rom_addr,     32'h0);
    @(posedge clk);
    #1;
    check("rst_seq d_rvalid", 32'(d_rvalid), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d if_rvalid", i), 32'(if_rvalid), 32'h0);
      check($sformatf("post_rst%0d d_rvalid", i),  32'(d_rvalid),  32'h0);
      check($sformatf("post_rst%0d cnt", i),       32'(dbg_cnt),   32'h0);
      check($sformatf("post_rst%0d rom_addr", i),  rom_addr,       32'h0);
      check($sformatf("post_rst%0d d_rdata", i),   d_rdata,        32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
